// File: rtl/modmul_pkg.sv
// Shared types and sizing helpers for the ModMul request scheduler.
package modmul_pkg;

    // Scheduler FSM states; only one operation is ever in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Operand/result width of the shared ModMul instance.
    localparam int MODMUL_WIDTH = 128;

    // Bits needed for a RUN cycle counter that must be able to hold TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/modmul_scheduler_rr_pick.sv
// Round-robin picker: grants the first valid requester at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;

    // Scan N positions starting at ptr; the first valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int            j;
            logic [IW-1:0] j_idx;
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IW'(j);
            if (!found && valid[j_idx]) begin
                found        = 1'b1;
                grant[j_idx] = 1'b1;
                idx          = j_idx;
            end
        end
    end

endmodule

// File: rtl/modmul_scheduler.sv
// Shares one external ModMul instance between NREQ requesters.
// Flow per operation: IDLE (accept) -> CLR (ModMul reset) -> RUN -> RESP.
module modmul_scheduler
    import modmul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = MODMUL_WIDTH,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_r,
    output logic [WIDTH-1:0]      mm_a,
    output logic [WIDTH-1:0]      mm_b,
    output logic                  mm_reset,
    output logic                  mm_enable,
    input  logic [WIDTH-1:0]      mm_r,
    input  logic                  mm_done,
    output logic                  busy,
    output logic                  timeout_err,
    output state_t                dbg_state
);

    // Handshakes: a request transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; a result transfers when rsp_valid[i] and
    // rsp_ready[i] are both high. Ready/valid of other requesters is ignored.

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            any_req;
    logic            run_expired;

    assign any_req     = |req_valid;
    assign run_expired = (cnt_q == CW'(TIMEOUT));
    assign dbg_state   = state_q;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Next-state and control outputs; reset overrides everything combinationally.
    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        rsp_valid   = '0;
        mm_reset    = 1'b0;
        mm_enable   = 1'b0;
        busy        = 1'b1;
        timeout_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    req_ready = pick_grant;
                    state_d   = ST_CLR;
                end
            end
            ST_CLR: begin
                mm_reset = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                mm_enable = 1'b1;
                if (mm_done) begin
                    state_d = ST_RESP;
                end else if (run_expired) begin
                    timeout_err = 1'b1;
                    mm_reset    = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            state_d     = ST_IDLE;
            req_ready   = '0;
            rsp_valid   = '0;
            mm_enable   = 1'b0;
            mm_reset    = 1'b1;
            busy        = 1'b0;
            timeout_err = 1'b0;
        end
    end

    // State register plus operand/owner latching, RUN counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            rsp_r    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q  <= pick_idx;
                        rr_ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        mm_a     <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
                        mm_b     <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
                        cnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mm_done) begin
                        rsp_r <= mm_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modmul_scheduler.sv
// Bench for modmul_scheduler with a small ModMul model (p=37, done 6 cycles
// after enable) and a result scoreboard.
module tb_modmul_scheduler;
    import modmul_pkg::*;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 16;
    localparam int TIMEOUT  = 15;
    localparam int IW       = 2;
    localparam int P        = 37;
    localparam int DONE_LAT = 6;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '0;
    logic [WIDTH-1:0]      rsp_r, mm_a, mm_b, mm_r;
    logic                  mm_reset, mm_enable, mm_done, busy, timeout_err;
    state_t                dbg_state;

    logic [WIDTH-1:0]      a_val [NREQ];
    logic [WIDTH-1:0]      b_val [NREQ];
    logic [IW+WIDTH-1:0]   exp_q [$];
    int                    checks = 0;
    int                    passes = 0;
    int                    cyc = 0;
    logic                  m_done_en = 1'b1;
    logic [7:0]            m_cnt = '0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pack per-requester operands onto the wide buses.
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_val[i];
            req_b[i*WIDTH +: WIDTH] = b_val[i];
        end
    end

    // ModMul model: counts enabled cycles since its reset.
    always @(posedge clk) begin
        if (mm_reset) m_cnt <= '0;
        else if (mm_enable) m_cnt <= m_cnt + 1'b1;
    end
    assign mm_done = m_done_en && mm_enable && (m_cnt == 8'(DONE_LAT));
    assign mm_r    = WIDTH'((32'(mm_a) * 32'(mm_b)) % P);

    modmul_scheduler #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_r       (rsp_r),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_reset    (mm_reset),
        .mm_enable   (mm_enable),
        .mm_r        (mm_r),
        .mm_done     (mm_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    function automatic logic [WIDTH-1:0] exp_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return WIDTH'((32'(a) * 32'(b)) % P);
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            a_val[i] = WIDTH'(i + 3);
            b_val[i] = WIDTH'(i + 11);
        end
        repeat (3) tick();
        checks++;
        if ({req_ready, rsp_valid, mm_reset, mm_enable, busy, timeout_err} !== {4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: got rdy=%b vld=%b mrst=%b men=%b busy=%b to=%b, want 0000 0000 1 0 0 0",
                     req_ready, rsp_valid, mm_reset, mm_enable, busy, timeout_err);
        else passes++;
        checks++;
        if ({mm_a, mm_b, rsp_r} !== 48'h0)
            $display("FAIL reset_data: got mm_a=%h mm_b=%h rsp_r=%h, want 0", mm_a, mm_b, rsp_r);
        else passes++;
        checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        else passes++;
        reset = 1'b0;
        req_valid = '0;
        tick();
        checks++;
        if ({busy, mm_reset} !== 2'b00) $display("FAIL reset_release: got busy/mm_reset=%b want 00", {busy, mm_reset});
        else passes++;
    endtask

    task automatic test_single;
        int t0;
        logic [IW+WIDTH-1:0] e;
        a_val[0] = 16'd5;
        b_val[0] = 16'd9;
        rsp_ready = 4'b0001;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_accept: got %b want 0001", req_ready);
        else passes++;
        exp_q.push_back({2'd0, 16'd8});
        t0 = cyc;
        tick();
        req_valid = '0;
        #1;
        checks++;
        if ({mm_reset, mm_enable, busy, mm_a, mm_b} !== {3'b101, 16'd5, 16'd9})
            $display("FAIL single_clr: got mrst=%b men=%b busy=%b a=%0d b=%0d want 1 0 1 5 9",
                     mm_reset, mm_enable, busy, mm_a, mm_b);
        else passes++;
        for (int t = 0; t < 40 && rsp_valid == '0; t++) tick();
        checks++;
        if (cyc - t0 !== 9) $display("FAIL single_latency: got %0d cycles want 9", cyc - t0);
        else passes++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL single_rsp: unexpected rsp_valid=%b", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid, rsp_r} !== {4'b0001 << e[WIDTH +: IW], e[WIDTH-1:0]})
                $display("FAIL single_rsp: got vld=%b r=%0d want vld=%b r=%0d",
                         rsp_valid, rsp_r, 4'b0001 << e[WIDTH +: IW], e[WIDTH-1:0]);
            else passes++;
        end
        tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy);
        else passes++;
    endtask

    // Holds vmask valid; expects n grants in the order packed in ord (2 bits each).
    task automatic test_grant_sequence(input string name, input logic [3:0] vmask, input int n, input logic [15:0] ord);
        int g;
        int r;
        logic want_next;
        logic [IW-1:0] gi;
        logic [IW+WIDTH-1:0] e;
        for (int i = 0; i < NREQ; i++) begin
            a_val[i] = WIDTH'($urandom_range(0, P - 1));
            b_val[i] = WIDTH'($urandom_range(0, P - 1));
        end
        for (int k = 0; k < n; k++) begin
            gi = ord[2*k +: 2];
            exp_q.push_back({gi, exp_res(a_val[gi], b_val[gi])});
        end
        g = 0;
        r = 0;
        want_next = 1'b0;
        rsp_ready = 4'hF;
        req_valid = vmask;
        #1;
        for (int t = 0; t < 300 && r < n; t++) begin
            if (want_next) begin
                checks++;
                if (req_ready === 4'b0000) $display("FAIL %s_b2b: got req_ready=%b want a grant", name, req_ready);
                else passes++;
                want_next = 1'b0;
            end
            if (req_ready !== 4'b0000) begin
                gi = ord[2*g +: 2];
                checks++;
                if (req_ready !== (4'b0001 << gi)) $display("FAIL %s_grant%0d: got %b want %b", name, g, req_ready, 4'b0001 << gi);
                else passes++;
                g++;
            end
            if (rsp_valid !== 4'b0000) begin
                checks++;
                if (req_ready !== 4'b0000) $display("FAIL %s_hs_nogrant: got req_ready=%b want 0000", name, req_ready);
                else passes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL %s_rsp: unexpected rsp_valid=%b", name, rsp_valid);
                else begin
                    e = exp_q.pop_front();
                    if ({rsp_valid, rsp_r} !== {4'b0001 << e[WIDTH +: IW], e[WIDTH-1:0]})
                        $display("FAIL %s_rsp%0d: got vld=%b r=%0d want vld=%b r=%0d", name, r,
                                 rsp_valid, rsp_r, 4'b0001 << e[WIDTH +: IW], e[WIDTH-1:0]);
                    else passes++;
                end
                r++;
                if (g < n) want_next = 1'b1;
            end
            @(negedge clk);
            if (g >= n) req_valid = '0;
            #1;
        end
        req_valid = '0;
        checks++;
        if (r !== n) $display("FAIL %s_count: got %0d responses want %0d", name, r, n);
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_backpressure;
        int bad;
        logic [IW+WIDTH-1:0] e;
        a_val[2] = WIDTH'($urandom_range(1, P - 1));
        b_val[2] = WIDTH'($urandom_range(1, P - 1));
        a_val[0] = WIDTH'($urandom_range(1, P - 1));
        b_val[0] = WIDTH'($urandom_range(1, P - 1));
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL bp_accept: got %b want 0100", req_ready);
        else passes++;
        exp_q.push_back({2'd2, exp_res(a_val[2], b_val[2])});
        tick();
        req_valid = 4'b0001;
        #1;
        for (int t = 0; t < 40 && rsp_valid == '0; t++) tick();
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            if ({rsp_valid, req_ready, rsp_r} !== {4'b0100, 4'b0000, exp_q[0][WIDTH-1:0]}) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        else passes++;
        rsp_ready = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL bp_hs_nogrant: got req_ready=%b want 0000", req_ready);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_r} !== {4'b0100, e[WIDTH-1:0]})
            $display("FAIL bp_rsp: got vld=%b r=%0d want vld=0100 r=%0d", rsp_valid, rsp_r, e[WIDTH-1:0]);
        else passes++;
        tick();
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL bp_next_grant: got %b want 0001", req_ready);
        else passes++;
        exp_q.push_back({2'd0, exp_res(a_val[0], b_val[0])});
        rsp_ready = 4'b0101;
        tick();
        req_valid = '0;
        #1;
        for (int t = 0; t < 40 && rsp_valid == '0; t++) tick();
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_r} !== {4'b0001, e[WIDTH-1:0]})
            $display("FAIL bp_rsp0: got vld=%b r=%0d want vld=0001 r=%0d", rsp_valid, rsp_r, e[WIDTH-1:0]);
        else passes++;
        tick();
    endtask

    task automatic test_timeout;
        int t0;
        int bad;
        logic seen;
        logic [IW+WIDTH-1:0] e;
        m_done_en = 1'b0;
        rsp_ready = 4'hF;
        a_val[1] = 16'd4;
        b_val[1] = 16'd6;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL to_accept: got %b want 0010", req_ready);
        else passes++;
        t0 = cyc;
        tick();
        req_valid = '0;
        #1;
        bad = 0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (rsp_valid !== 4'b0000) bad++;
            if (timeout_err === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (seen !== 1'b1 || cyc - t0 !== 17)
            $display("FAIL to_pulse: got seen=%b at cycle %0d want seen=1 at 17", seen, cyc - t0);
        else passes++;
        checks++;
        if ({mm_reset, mm_enable} !== 2'b11) $display("FAIL to_mm_ctrl: got mrst/men=%b want 11", {mm_reset, mm_enable});
        else passes++;
        tick();
        for (int t = 0; t < 5; t++) begin
            if ({timeout_err, busy, rsp_valid} !== 6'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) $display("FAIL to_quiet: got %0d bad cycles want 0", bad);
        else passes++;
        m_done_en = 1'b1;
        a_val[3] = 16'd20;
        b_val[3] = 16'd30;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) $display("FAIL to_next_accept: got %b want 1000", req_ready);
        else passes++;
        exp_q.push_back({2'd3, exp_res(16'd20, 16'd30)});
        tick();
        req_valid = '0;
        #1;
        for (int t = 0; t < 40 && rsp_valid == '0; t++) tick();
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_r} !== {4'b1000, e[WIDTH-1:0]})
            $display("FAIL to_next_rsp: got vld=%b r=%0d want vld=1000 r=%0d", rsp_valid, rsp_r, e[WIDTH-1:0]);
        else passes++;
        tick();
    endtask

    task automatic test_reset_in_run;
        int bad;
        a_val[2] = 16'd7;
        b_val[2] = 16'd8;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        #1;
        for (int t = 0; t < 10 && mm_enable !== 1'b1; t++) tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({mm_reset, mm_enable, busy} !== 3'b100) $display("FAIL rr_during: got mrst/men/busy=%b want 100", {mm_reset, mm_enable, busy});
        else passes++;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mm_enable, busy, timeout_err, mm_a, mm_b, rsp_r} !== '0 || dbg_state !== ST_IDLE)
            $display("FAIL rr_after: got rdy=%b vld=%b men=%b busy=%b a=%0d b=%0d r=%0d st=%0d want all 0",
                     req_ready, rsp_valid, mm_enable, busy, mm_a, mm_b, rsp_r, dbg_state);
        else passes++;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            if ({rsp_valid, busy} !== 5'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) $display("FAIL rr_no_rsp: got %0d bad cycles want 0", bad);
        else passes++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_grant_sequence("contention", 4'hF, 5, 16'h00E4);
        test_backpressure();
        test_timeout();
        test_reset_in_run();
        test_grant_sequence("wrap", 4'b1010, 3, 16'h001D);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/modmul_scheduler.md
MODMUL_SCHEDULER -- requirements
Module: modmul_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one ModMul instance (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 128: operand and result width; it matches the ModMul width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023: maximum RUN cycles before an abort.
REQ-004 The block SHALL have port clk  in  1  single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-007 The block SHALL have port req_ready  out  NREQ  one-hot accept; it is high only for the granted requester in the accept cycle.
REQ-008 The block SHALL have port req_a, req_b  in  NREQ*WIDTH  packed operands; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port rsp_valid  out  NREQ  one-hot result valid to the owning requester.
REQ-010 The block SHALL have port rsp_ready  in  NREQ  per-requester result accept.
REQ-011 The block SHALL have port rsp_r  out  WIDTH  result, shared by all requesters; it is qualified by rsp_valid.
REQ-012 The block SHALL have port mm_a, mm_b  out  WIDTH  operands to ModMul; they are registered and held stable from the CLR state through the RUN state.
REQ-013 The block SHALL have port mm_reset  out  1  ModMul reset; it is high in reset and in the CLR state.
REQ-014 The block SHALL have port mm_enable  out  1  ModMul enable; it is high for the whole RUN state.
REQ-015 The block SHALL have ports mm_r  in  WIDTH  and  mm_done  in  1  ModMul result and completion.
REQ-016 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 The block SHALL have port timeout_err  out  1  one-cycle pulse when a RUN is aborted.

Function
REQ-018 The FSM SHALL have the states IDLE, CLR, RUN and RESP; only one operation SHALL be in flight at any time.
REQ-019 IDLE: if any req_valid is high, the FSM SHALL do the following in the same cycle, then go to CLR:
- grant the first valid requester at or after rr_ptr (round-robin, wrapping from NREQ-1 to 0);
- raise req_ready for that requester;
- latch its operands into mm_a and mm_b and record owner.
REQ-020 On each grant, rr_ptr SHALL become owner+1 modulo NREQ; with no request it SHALL hold.
REQ-021 CLR SHALL last exactly one cycle with mm_reset=1 and mm_enable=0, then go to RUN.
REQ-022 RUN SHALL hold mm_enable=1 and increment a cycle counter from 0.
REQ-023 When mm_done=1 in RUN, the block SHALL latch mm_r into rsp_r and go to RESP.
REQ-024 When the RUN counter reaches TIMEOUT without mm_done, the block SHALL pulse timeout_err, drive mm_reset=1 for that cycle, and return to IDLE without issuing a response.
REQ-025 RESP SHALL drive rsp_valid[owner]=1 with rsp_r stable until rsp_ready[owner]=1, then go to IDLE; rsp_ready of other requesters SHALL be ignored.
REQ-026 Minimum latency, counting the accept cycle as 0: CLR at cycle 1, RUN from cycle 2, rsp_valid on the cycle after mm_done.
REQ-027 Back-to-back operation: an operation SHALL be accepted in the IDLE cycle that directly follows the rsp handshake; a new grant SHALL never be given in the same cycle as a rsp handshake.
REQ-028 req_valid that drops before it is granted SHALL be ignored; no request SHALL be lost while it is held; a late mm_done outside RUN SHALL be ignored.

Reset
REQ-029 While reset=1, the block SHALL force state=IDLE, rr_ptr=0, owner=0, counter=0, req_ready=0, rsp_valid=0, rsp_r=0, mm_a=0, mm_b=0, mm_enable=0, mm_reset=1, busy=0 and timeout_err=0.
REQ-030 Reset asserted mid-operation SHALL abort that operation with no response; the first grant after reset SHALL go to the lowest-index valid requester.

Structure
REQ-031 A shared package modmul_pkg SHALL hold the FSM state enum, the default WIDTH, and the counter width function clog2(TIMEOUT+1).
REQ-032 The round-robin picker SHALL be one combinational sub-module rr_pick (inputs: valid vector and pointer; outputs: one-hot grant and index); there SHALL be no other sub-modules, and ModMul SHALL be instantiated outside the block.

Verification
REQ-033 Single request: requester 0 gives a=5, b=9 with a ModMul model (p=37, done 6 cycles after enable) -> rsp_valid[0] with rsp_r=8, and the rsp_valid cycle is 9 cycles after accept.
REQ-034 Contention: all four requesters held valid after reset -> grants in order 0,1,2,3,0, each with the correct product mod 37.
REQ-035 Backpressure: rsp_ready[2] held low for 10 cycles -> rsp_valid[2] and rsp_r held stable and no new grant; the grant comes in the cycle after the handshake.
REQ-036 Timeout: TIMEOUT=15 and the model never raises done -> timeout_err pulses at RUN cycle 15, no rsp_valid, and the next request is served normally.
REQ-037 Reset in RUN: reset asserted for one cycle -> all outputs at reset values on the next cycle, no response, rr_ptr=0.
REQ-038 Wrap: only requesters 3 and 1 valid with rr_ptr=2 -> grants 3 then 1.
